// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_buf
//  Description : Elastic inter-stage pipeline register with valid/ready
//                handshake, optional skid entry (registered in_ready) and a
//                synchronous flush that forces a bubble on the control field.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int                 DATA_W      = 96,
  parameter int                 CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int                 SKID        = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        out_count
);

  // State values equal the number of entries held, so the count output is
  // simply the state register.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] c_DATA_CLR = '0;

  state_t              r_state;
  logic [DATA_W-1:0]   r_head_data;
  logic [CTRL_W-1:0]   r_head_ctrl;
  logic [DATA_W-1:0]   r_skid_data;
  logic [CTRL_W-1:0]   r_skid_ctrl;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_head_data_nxt;
  logic [CTRL_W-1:0]   w_head_ctrl_nxt;
  logic [DATA_W-1:0]   w_skid_data_nxt;
  logic [CTRL_W-1:0]   w_skid_ctrl_nxt;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_in_fire;
  logic                w_out_fire;

  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_in_fire   = in_valid & w_in_ready;
  assign w_out_fire  = w_out_valid & out_ready;

  // in_ready source depends on the skid option: a flop decoded from the
  // next state (no out_ready -> in_ready path) or the classic combinational
  // "empty or draining" term.
  generate
    if (SKID != 0) begin : g_skid_ready
      logic r_in_ready;

      // Registered ready: low only while both entries are occupied.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_FULL);
        end
      end

      assign w_in_ready = r_in_ready;
    end else begin : g_comb_ready
      assign w_in_ready = ~w_out_valid | out_ready;
    end
  endgenerate

  // Next-state and entry update. Empty entries always hold zero data and the
  // bubble control value so downstream never sees garbage.
  always_comb begin
    w_state_nxt     = r_state;
    w_head_data_nxt = r_head_data;
    w_head_ctrl_nxt = r_head_ctrl;
    w_skid_data_nxt = r_skid_data;
    w_skid_ctrl_nxt = r_skid_ctrl;

    if (flush) begin
      // Flush discards held entries and any same-cycle transfer.
      w_state_nxt     = ST_EMPTY;
      w_head_data_nxt = c_DATA_CLR;
      w_head_ctrl_nxt = CTRL_BUBBLE;
      w_skid_data_nxt = c_DATA_CLR;
      w_skid_ctrl_nxt = CTRL_BUBBLE;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt     = ST_HALF;
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end
        end

        ST_HALF: begin
          if (w_in_fire && w_out_fire) begin
            // Back-to-back: the head is replaced in place.
            w_head_data_nxt = in_data;
            w_head_ctrl_nxt = in_ctrl;
          end else if (w_in_fire) begin
            // Only reachable with a skid entry; without it in_ready
            // already requires out_ready while the head is occupied.
            if (SKID != 0) begin
              w_state_nxt     = ST_FULL;
              w_skid_data_nxt = in_data;
              w_skid_ctrl_nxt = in_ctrl;
            end
          end else if (w_out_fire) begin
            w_state_nxt     = ST_EMPTY;
            w_head_data_nxt = c_DATA_CLR;
            w_head_ctrl_nxt = CTRL_BUBBLE;
          end
        end

        ST_FULL: begin
          // in_ready is low here, so only the output side can move.
          if (w_out_fire) begin
            w_state_nxt     = ST_HALF;
            w_head_data_nxt = r_skid_data;
            w_head_ctrl_nxt = r_skid_ctrl;
            w_skid_data_nxt = c_DATA_CLR;
            w_skid_ctrl_nxt = CTRL_BUBBLE;
          end
        end

        default: begin
          w_state_nxt     = ST_EMPTY;
          w_head_data_nxt = c_DATA_CLR;
          w_head_ctrl_nxt = CTRL_BUBBLE;
          w_skid_data_nxt = c_DATA_CLR;
          w_skid_ctrl_nxt = CTRL_BUBBLE;
        end
      endcase
    end
  end

  // State and entry registers, cleared to the bubble on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_head_data <= c_DATA_CLR;
      r_head_ctrl <= CTRL_BUBBLE;
      r_skid_data <= c_DATA_CLR;
      r_skid_ctrl <= CTRL_BUBBLE;
    end else begin
      r_state     <= w_state_nxt;
      r_head_data <= w_head_data_nxt;
      r_head_ctrl <= w_head_ctrl_nxt;
      r_skid_data <= w_skid_data_nxt;
      r_skid_ctrl <= w_skid_ctrl_nxt;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_head_data;
  assign out_ctrl  = r_head_ctrl;
  assign out_count = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_buf
//  Description : Scoreboard bench for pipe_stage_buf; lane 0 uses SKID=1,
//                lane 1 uses SKID=0. Reference is a plain FIFO of capacity
//                2 (skid) or 1 (no skid).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buf;

  localparam int              DW  = 96;
  localparam int              CW  = 16;
  localparam logic [CW-1:0]   BUB = 16'h0100;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [1:0]    out_count [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int SK = (g == 0) ? 1 : 0;
    logic [DW+CW-1:0] q [$];
    logic [DW+CW-1:0] exp_item;

    pipe_stage_buf #(
      .DATA_W(DW), .CTRL_W(CW), .CTRL_BUBBLE(BUB), .SKID(SK)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[g]),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .in_data  (in_data[g]),
      .in_ctrl  (in_ctrl[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_data (out_data[g]),
      .out_ctrl (out_ctrl[g]),
      .out_count(out_count[g])
    );

    // Stimulus side of the scoreboard: accepted inputs enter the FIFO.
    always @(posedge clk) begin
      if (rst || flush[g]) q.delete();
      else if (in_valid[g] && in_ready[g]) q.push_back({in_ctrl[g], in_data[g]});
    end

    // Monitor: every output transfer must be the oldest accepted item.
    always @(posedge clk) begin
      if (!rst && !flush[g] && out_valid[g] && out_ready[g]) begin
        if (q.size() == 0) begin
          chk($sformatf("lane%0d out_fire_on_empty", g), 128'd1, 128'd0);
        end else begin
          exp_item = q.pop_front();
          chk($sformatf("lane%0d out_item", g), {out_ctrl[g], out_data[g]}, exp_item);
        end
      end
    end

    // Post-edge state check against the FIFO model.
    always @(posedge clk) begin
      #1;
      if (!rst) begin
        chk($sformatf("lane%0d out_valid", g), out_valid[g], q.size() != 0);
        chk($sformatf("lane%0d out_count", g), out_count[g], q.size());
        if (SK != 0)
          chk($sformatf("lane%0d in_ready", g), in_ready[g], q.size() < 2);
        else
          chk($sformatf("lane%0d in_ready", g), in_ready[g], (q.size() == 0) || out_ready[g]);
        if (q.size() != 0)
          chk($sformatf("lane%0d head", g), {out_ctrl[g], out_data[g]}, q[0]);
        else
          chk($sformatf("lane%0d bubble", g), {out_ctrl[g], out_data[g]}, {BUB, {DW{1'b0}}});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set(input int g, input logic v, input logic [DW-1:0] d,
                     input logic ordy, input logic fl);
    in_valid[g]  = v;
    in_data[g]   = d;
    in_ctrl[g]   = d[CW-1:0] ^ 16'h5A5A;
    out_ready[g] = ordy;
    flush[g]     = fl;
  endtask

  task automatic idle_all();
    for (int g = 0; g < 2; g++) set(g, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    int pv, pr;
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    chk("reset in_ready lane0", in_ready[0], 1'b1);
    chk("reset count lane0", out_count[0], 2'd0);
    tick();

    // Async reset mid-stream with two entries held
    set(0, 1'b1, 96'hA1, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hA2, 1'b0, 1'b0); tick();
    chk("pre-reset count", out_count[0], 2'd2);
    #3 rst = 1'b1;
    #1;
    chk("async rst out_valid", out_valid[0], 1'b0);
    chk("async rst out_ctrl", out_ctrl[0], BUB);
    chk("async rst out_data", out_data[0], '0);
    chk("async rst out_count", out_count[0], 2'd0);
    idle_all();
    @(posedge clk);
    #2 rst = 1'b0;
    chk("post-reset in_ready", in_ready[0], 1'b1);
    tick();

    // Streaming on both lanes
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) begin
        set(g, 1'b1, 96'h10 + 96'(i), 1'b1, 1'b0);
        tick();
        chk("stream data", out_data[g], 96'h10 + 96'(i));
        chk("stream count", out_count[g], 2'd1);
      end
      set(g, 1'b0, '0, 1'b1, 1'b0);
      tick();
      chk("stream drained", out_valid[g], 1'b0);
    end

    // Backpressure with skid: A,B accepted, C held upstream
    set(0, 1'b1, 96'hA, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hB, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hC, 1'b0, 1'b0); tick();
    chk("bp count", out_count[0], 2'd2);
    chk("bp in_ready", in_ready[0], 1'b0);
    chk("bp head A", out_data[0], 96'hA);
    tick();
    chk("bp stall head A", out_data[0], 96'hA);
    set(0, 1'b1, 96'hC, 1'b1, 1'b0); tick();
    chk("bp head B", out_data[0], 96'hB);
    tick();
    chk("bp head C", out_data[0], 96'hC);
    set(0, 1'b0, '0, 1'b1, 1'b0); tick();
    chk("bp drained", out_valid[0], 1'b0);

    // Flush with two entries held, plus a same-cycle in_fire flush from one entry
    set(0, 1'b1, 96'hD1, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hD2, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hD3, 1'b1, 1'b1); tick();
    chk("flush full out_valid", out_valid[0], 1'b0);
    chk("flush full out_ctrl", out_ctrl[0], BUB);
    set(0, 1'b1, 96'hE1, 1'b0, 1'b0); tick();
    set(0, 1'b1, 96'hE2, 1'b0, 1'b1); tick();
    chk("flush infire out_valid", out_valid[0], 1'b0);
    chk("flush infire out_ctrl", out_ctrl[0], BUB);
    set(0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush nothing later", out_valid[0], 1'b0);
    end

    // No-skid lane: out_ready toggling with continuous in_valid
    for (int i = 0; i < 8; i++) begin
      set(1, 1'b1, 96'h200 + 96'(i), (i % 3) != 1, 1'b0);
      tick();
    end
    set(1, 1'b0, '0, 1'b1, 1'b0);
    tick(); tick();
    chk("noskid drained", out_valid[1], 1'b0);

    // Random valid/ready/flush on both lanes
    for (int c = 0; c < 10000; c++) begin
      pv = 15 + ((c / 700) * 23) % 85;
      pr = 10 + ((c / 500) * 37) % 90;
      for (int g = 0; g < 2; g++) begin
        in_valid[g]  = ($urandom_range(0, 99) < pv);
        out_ready[g] = ($urandom_range(0, 99) < pr);
        flush[g]     = ($urandom_range(0, 99) == 0);
        in_data[g]   = {$urandom, $urandom, $urandom};
        in_ctrl[g]   = 16'($urandom);
      end
      tick();
    end

    for (int g = 0; g < 2; g++) set(g, 1'b0, '0, 1'b1, 1'b0);
    repeat (4) tick();
    chk("final lane0 empty", out_valid[0], 1'b0);
    chk("final lane1 empty", out_valid[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
